// File: rtl/conv_enc_if.sv
// Handshake bundle for conv_enc: serial data bits in, 2-bit code symbols out.
// master = the encoder side, slave = the surrounding source/sink.
interface conv_enc_if;
    logic       d_in;
    logic       d_in_vld;
    logic       d_in_last;
    logic       in_ready;
    logic [1:0] d_o;
    logic       d_o_vld;
    logic       d_o_last;
    logic [1:0] d_o_mask;
    logic       d_o_rdy;

    modport master (
        input  d_in, d_in_vld, d_in_last, d_o_rdy,
        output in_ready, d_o, d_o_vld, d_o_last, d_o_mask
    );

    modport slave (
        output d_in, d_in_vld, d_in_last, d_o_rdy,
        input  in_ready, d_o, d_o_vld, d_o_last, d_o_mask
    );
endinterface

// File: rtl/conv_enc.sv
// Rate-1/2, K=4 convolutional encoder with 3-bit zero tail per frame.
// Define CONV_ENC_PUNCT_EN to generate the rate-2/3 puncturing keep mask.
module conv_enc #(
    parameter logic [3:0] G0        = 4'b1111,
    parameter logic [3:0] G1        = 4'b1101,
    parameter int         FRAME_LEN = 64,
    parameter int         CNT_W     = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    conv_enc_if.master    io,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

    state_t           state;
    logic [2:0]       s;
    logic [CNT_W-1:0] bit_cnt;
    logic [1:0]       tail_cnt;

    logic             adv;
    logic             in_xfer;
    logic             tail_step;
    logic             last_tail;
    logic             gen;
    logic             u;
    logic [3:0]       v;
    logic             c0;
    logic             c1;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic             frame_end;

    // Output register may only be reloaded when it is empty or being drained.
    assign adv         = !io.d_o_vld || io.d_o_rdy;
    assign io.in_ready = enable && adv && (state == IDLE || state == DATA);
    assign in_xfer     = io.d_in_vld && io.in_ready;
    assign tail_step   = enable && adv && (state == TAIL);
    assign last_tail   = tail_step && (tail_cnt == 2'd2);
    assign gen         = in_xfer || tail_step;

    assign u  = in_xfer ? io.d_in : 1'b0;
    assign v  = {u, s};
    assign c0 = ^(v & G0);
    assign c1 = ^(v & G1);

    // Both termination conditions collapse into one TAIL entry.
    assign bit_cnt_nxt = (state == IDLE) ? CNT_W'(1) : bit_cnt + CNT_W'(1);
    assign frame_end   = io.d_in_last || (bit_cnt_nxt == LAST_CNT);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            s           <= 3'b000;
            bit_cnt     <= '0;
            tail_cnt    <= 2'd0;
            io.d_o      <= 2'b00;
            io.d_o_vld  <= 1'b0;
            io.d_o_last <= 1'b0;
        end else if (!enable) begin
            state       <= IDLE;
            s           <= 3'b000;
            bit_cnt     <= '0;
            tail_cnt    <= 2'd0;
            io.d_o      <= 2'b00;
            io.d_o_vld  <= 1'b0;
            io.d_o_last <= 1'b0;
        end else begin
            if (in_xfer) begin
                s       <= {u, s[2:1]};
                bit_cnt <= bit_cnt_nxt;
                state   <= frame_end ? TAIL : DATA;
            end else if (tail_step) begin
                if (last_tail) begin
                    s        <= 3'b000;
                    tail_cnt <= 2'd0;
                    bit_cnt  <= '0;
                    state    <= IDLE;
                end else begin
                    s        <= {1'b0, s[2:1]};
                    tail_cnt <= tail_cnt + 2'd1;
                end
            end

            if (adv) begin
                io.d_o_vld  <= gen;
                io.d_o_last <= last_tail;
                if (gen)
                    io.d_o <= {c1, c0};
            end
        end
    end

`ifdef CONV_ENC_PUNCT_EN
    logic phase;
    logic cur_phase;

    // A frame's first symbol always starts at phase 0.
    assign cur_phase = (state == IDLE) ? 1'b0 : phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase       <= 1'b0;
            io.d_o_mask <= 2'b11;
        end else if (!enable) begin
            phase       <= 1'b0;
            io.d_o_mask <= 2'b11;
        end else if (adv && gen) begin
            phase       <= ~cur_phase;
            io.d_o_mask <= cur_phase ? 2'b01 : 2'b11;
        end
    end
`else
    assign io.d_o_mask = 2'b11;
`endif

endmodule

// File: tb/tb_conv_enc.sv
// Scoreboard bench for conv_enc: driver pushes model symbols, monitor pops on transfer.
module tb_conv_enc;
    localparam int         FL = 4;
    localparam logic [3:0] G0 = 4'b1111;
    localparam logic [3:0] G1 = 4'b1101;

    typedef struct packed {
        logic [1:0] sym;
        logic       last;
        logic [1:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic busy;
    logic rand_rdy = 1'b0;
    logic rdy_force = 1'b1;
    logic rnd = 1'b1;

    conv_enc_if io();

    conv_enc #(.G0(G0), .G1(G1), .FRAME_LEN(FL), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .enable(enable), .io(io), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd = ($urandom % 4) != 0;
    end
    assign io.d_o_rdy = rand_rdy ? rnd : rdy_force;

    exp_t q[$];
    bit   h[$];
    int   m_cnt = 0;
    int   m_idx = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: parity of generator taps over {u, previous three bits}.
    task automatic model_clear();
        h.delete();
        repeat (3) h.push_back(1'b0);
        m_cnt = 0;
        m_idx = 0;
    endtask

    task automatic m_sym(input bit u, input bit lst);
        exp_t e;
        bit   tap;
        bit   p0;
        bit   p1;
        p0 = 0;
        p1 = 0;
        for (int k = 0; k < 4; k++) begin
            tap = (k == 0) ? u : h[k-1];
            p0 ^= G0[3-k] & tap;
            p1 ^= G1[3-k] & tap;
        end
        e.sym  = {p1, p0};
        e.last = lst;
`ifdef CONV_ENC_PUNCT_EN
        e.mask = (m_idx % 2 == 0) ? 2'b11 : 2'b01;
`else
        e.mask = 2'b11;
`endif
        q.push_back(e);
        h.push_front(u);
        void'(h.pop_back());
        m_idx++;
    endtask

    task automatic model_data(input bit u, input bit last);
        m_sym(u, 1'b0);
        m_cnt++;
        if (last || m_cnt == FL) begin
            m_sym(1'b0, 1'b0);
            m_sym(1'b0, 1'b0);
            m_sym(1'b0, 1'b1);
            model_clear();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && io.d_o_vld && io.d_o_rdy) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_symbol: got d_o=%b last=%b with empty queue at %0t",
                         io.d_o, io.d_o_last, $time);
            end else begin
                e = q.pop_front();
                check("symbol{d_o,last,mask}", {27'd0, io.d_o, io.d_o_last, io.d_o_mask}, {27'd0, e});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the bit is accepted.
    task automatic send_bit(input bit u, input bit last);
        bit ok;
        io.d_in      = u;
        io.d_in_vld  = 1'b1;
        io.d_in_last = last;
        ok = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (io.in_ready) begin
                ok = 1;
                model_data(u, last);
                break;
            end
        end
        @(posedge clk);
        #1;
        io.d_in_vld  = 1'b0;
        io.d_in_last = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_basic();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy && !io.d_o_vld) begin
                done = 1;
                break;
            end
        end
        check("drain", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit got;
        bit lst;
        int len;
        io.d_in = 0;
        io.d_in_vld = 0;
        io.d_in_last = 0;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        check("rst_vld",  {31'd0, io.d_o_vld},  32'd0);
        check("rst_d_o",  {30'd0, io.d_o},      32'd0);
        check("rst_last", {31'd0, io.d_o_last}, 32'd0);
        check("rst_mask", {30'd0, io.d_o_mask}, 32'd3);
        check("rst_busy", {31'd0, busy},        32'd0);
        rst = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", {31'd0, io.in_ready}, 32'd1);

        // basic frame, twice back to back (state and phase restart)
        send_basic();
        check("busy_in_tail", {31'd0, busy}, 32'd1);
        send_basic();
        drain();
        check("busy_after", {31'd0, busy}, 32'd0);

        // backpressure during the second symbol
        fork
            send_basic();
            begin
                got = 0;
                for (int t = 0; t < 50 && !got; t++) begin
                    @(negedge clk);
                    if (io.d_o_vld && io.d_o_rdy) got = 1;
                end
                check("stall_sync", {31'd0, got}, 32'd1);
                @(posedge clk);
                #1 rdy_force = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_hold", {29'd0, io.d_o_vld, io.d_o}, {29'd0, 1'b1, 2'b11});
                    check("stall_in_ready", {31'd0, io.in_ready}, 32'd0);
                end
                @(posedge clk);
                #1 rdy_force = 1'b1;
            end
        join
        drain();

        // auto-terminate at FL data bits
        repeat (FL) send_bit(1'b1, 1'b0);
        @(negedge clk);
        check("autoterm_in_ready", {31'd0, io.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        drain();

        // enable drop mid-frame
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("en_drop_vld",  {31'd0, io.d_o_vld},  32'd0);
        check("en_drop_busy", {31'd0, busy},        32'd0);
        check("en_drop_last", {31'd0, io.d_o_last}, 32'd0);
        check("en_drop_q",    q.size(),             32'd0);
        model_clear();
        enable = 1'b1;
        @(posedge clk);
        #1;
        send_bit(1'b1, 1'b1);
        drain();

        // async reset while in TAIL
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_vld",  {31'd0, io.d_o_vld},  32'd0);
        check("arst_d_o",  {30'd0, io.d_o},      32'd0);
        check("arst_last", {31'd0, io.d_o_last}, 32'd0);
        check("arst_mask", {30'd0, io.d_o_mask}, 32'd3);
        check("arst_busy", {31'd0, busy},        32'd0);
        #2 rst = 1'b1;
        q.delete();
        model_clear();
        @(posedge clk);
        #1;
        send_bit(1'b1, 1'b1);
        drain();

        // randomized frames with gaps, stray d_in_last and random backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom % 3 == 0) begin
                    io.d_in_last = $urandom % 2;
                    @(posedge clk);
                    #1 io.d_in_last = 1'b0;
                end
                lst = (i == len - 1) && ($urandom % 4 != 0);
                send_bit($urandom % 2, lst);
            end
        end
        send_bit(1'b0, 1'b1);
        drain();
        rand_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
